contador_updown: RTL
====================

Name: contador_updown

Overview:
- Parametrised up/down successor of the team's loadable down-counter.
- Keeps the opcode-driven clear/hold/decrement/load model and the zero flag.
- Adds increment, a programmable upper limit, three boundary modes (wrap, saturate, auto-reload), a registered terminal-count pulse and sticky overflow/error flags.
- Used as loop/iteration counter and periodic timer inside datapath controllers.

Parameters:
- M, 6, counter width in bits (M >= 2).
- RST_VAL, 0, count value after reset and after CLR (must be <= any lim used).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- opc  input  3  operation: 0 CLR, 1 HOLD, 2 DEC, 3 LOAD, 4 INC, 5-7 HOLD (reserved)
- mode  input  2  boundary mode: 0 WRAP, 1 SAT, 2 RELOAD, 3 treated as SAT
- n  input  M  load value; reload value in RELOAD mode
- lim  input  M  inclusive upper limit of count range [0, lim]
- i  output  M  current count (registered)
- z  output  1  combinational, i == 0
- tc  output  1  registered one-cycle terminal-count pulse
- ovf  output  1  sticky: a boundary event has occurred since last CLR/rst
- err  output  1  sticky: LOAD with n > lim occurred since last CLR/rst

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk.
- All state updates occur on the rising clk edge. rst has priority over opc.
- Reset values: i = RST_VAL, tc = 0, ovf = 0, err = 0. z follows i.
- Registers are i, tc, ovf and err. Next-state logic is purely combinational from opc, mode, n, lim and i.
- CLR: i <= RST_VAL; ovf <= 0; err <= 0; tc <= 0.
- HOLD and reserved codes: i unchanged; tc <= 0; flags unchanged.
- LOAD:
  - n <= lim: i <= n.
  - n > lim: i <= lim and err <= 1.
  - tc <= 0.
- DEC when i != 0: i <= i - 1; tc <= 0.
- DEC when i == 0 (low boundary event): tc <= 1, ovf <= 1, and:
  - WRAP: i <= lim
  - SAT: i <= 0
  - RELOAD: i <= min(n, lim); if n > lim also set err
- INC when i < lim: i <= i + 1; tc <= 0.
- INC when i >= lim (high boundary event): tc <= 1, ovf <= 1, and:
  - WRAP: i <= 0
  - SAT: i <= lim (also pulls i down to lim if lim was lowered below i)
  - RELOAD: i <= 0
- Latency:
  - i changes 1 cycle after opc is sampled.
  - tc is high during exactly the cycle in which the post-boundary value is first visible on i.
  - Consecutive boundary events give back-to-back tc pulses, e.g. DEC held at 0 in SAT gives tc = 1 every cycle.
- Arithmetic is modulo 2^M internally, but results never leave [0, lim] except when lim is lowered while i > lim. In that case i holds until the next op. DEC from above lim decrements normally. INC is a high boundary event.
- lim = 0: counter pinned at 0. INC and DEC are boundary events each cycle; WRAP, SAT and RELOAD all yield 0.
- lim, n and mode are sampled only on the edge where they are used; no internal copies are kept.
- rst asserted mid-count: the next edge returns to reset values regardless of opc or mode; no tc is emitted.
- Unknown mode (3) behaves exactly as SAT.

Decomposition:
- Package contador_pkg:
  - opcode constants OPC_CLR, OPC_HOLD, OPC_DEC, OPC_LOAD, OPC_INC (3-bit typedef)
  - mode constants MODE_WRAP, MODE_SAT, MODE_RELOAD (2-bit typedef)
- One natural sub-module: contador_next, combinational.
  - Inputs: opc, mode, i, n, lim.
  - Outputs: next count, boundary-event flag, load-error flag.
  - Top holds only registers and the z compare.

Test Plan (M=6, RST_VAL=0):
- rst=1 for 1 edge while opc=INC -> i=0, tc=0, ovf=0, err=0, z=1. Then lim=5, mode=WRAP, INC x6 -> i=1,2,3,4,5,0; tc=1 only on the cycle i returns to 0; ovf=1.
- lim=63, LOAD n=3, then DEC x4 in SAT -> i=2,1,0,0; tc=1 only on the 4th result; z=1 from the 3rd DEC on.
- RELOAD mode, lim=40, LOAD n=2, DEC held 9 cycles -> i=1,0,2,1,0,2,1,0,2; tc high on each return to 2; ovf=1, err=0.
- lim=10, LOAD n=50 -> i=10, err=1. Then CLR -> i=0, err=0, ovf=0. Then HOLD x3 with opc codes 1,5,7 -> i stays 0, tc=0.
- lim=20, LOAD 15, then lim=8, INC in SAT -> i=8, tc=1. Same setup with DEC instead -> i=14, tc=0.
- Mid-sequence rst: at i=4 counting up in WRAP with lim=5, rst=1 and opc=INC on the same edge -> i=0, tc=0, ovf cleared.

Source files
------------

// File: rtl/contador_pkg.sv
// Shared opcode and boundary-mode encodings for the up/down counter.
package contador_pkg;

    // Operation codes; 5..7 are reserved and behave as HOLD
    typedef enum logic [2:0] {
        OPC_CLR  = 3'd0,
        OPC_HOLD = 3'd1,
        OPC_DEC  = 3'd2,
        OPC_LOAD = 3'd3,
        OPC_INC  = 3'd4
    } opc_e;

    // Boundary behaviour; code 3 is handled as SAT
    typedef enum logic [1:0] {
        MODE_WRAP   = 2'd0,
        MODE_SAT    = 2'd1,
        MODE_RELOAD = 2'd2
    } mode_e;

endpackage

// File: rtl/contador_next.sv
// Combinational next-count logic: decodes the opcode, applies the boundary
// mode and flags boundary events and out-of-range loads.
module contador_next
    import contador_pkg::*;
#(
    parameter int              M       = 6,
    parameter logic [M-1:0]    RST_VAL = '0
) (
    input  logic [2:0]   i_opc,
    input  logic [1:0]   i_mode,
    input  logic [M-1:0] i_cnt,
    input  logic [M-1:0] i_n,
    input  logic [M-1:0] i_lim,
    output logic [M-1:0] o_next,
    output logic         o_bnd,
    output logic         o_lerr
);

    localparam logic [M-1:0] ONE_M = M'(1);

    logic         w_n_gt_lim;
    logic [M-1:0] w_n_clip;

    // A load/reload value above the limit is clipped to the limit
    assign w_n_gt_lim = (i_n > i_lim);
    assign w_n_clip   = w_n_gt_lim ? i_lim : i_n;

    // Next count selection; anything not listed keeps the current count
    always_comb begin
        o_next = i_cnt;
        o_bnd  = 1'b0;
        o_lerr = 1'b0;
        case (i_opc)
            OPC_CLR: begin
                o_next = RST_VAL;
            end
            OPC_LOAD: begin
                o_next = w_n_clip;
                o_lerr = w_n_gt_lim;
            end
            OPC_DEC: begin
                if (i_cnt != '0) begin
                    // Also the path when lim was lowered below the count
                    o_next = i_cnt - ONE_M;
                end else begin
                    o_bnd = 1'b1;
                    case (i_mode)
                        MODE_WRAP:   o_next = i_lim;
                        MODE_RELOAD: begin
                            o_next = w_n_clip;
                            o_lerr = w_n_gt_lim;
                        end
                        default:     o_next = '0;
                    endcase
                end
            end
            OPC_INC: begin
                if (i_cnt < i_lim) begin
                    o_next = i_cnt + ONE_M;
                end else begin
                    // Reaching or sitting above the limit counts as a boundary
                    o_bnd = 1'b1;
                    case (i_mode)
                        MODE_WRAP,
                        MODE_RELOAD: o_next = '0;
                        default:     o_next = i_lim;
                    endcase
                end
            end
            default: begin
                o_next = i_cnt;
            end
        endcase
    end

endmodule

// File: rtl/contador_updown.sv
// Parametrised up/down counter with programmable inclusive limit, boundary
// modes, registered terminal-count pulse and sticky overflow/error flags.
module contador_updown
    import contador_pkg::*;
#(
    parameter int           M       = 6,
    parameter logic [M-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   opc,
    input  logic [1:0]   mode,
    input  logic [M-1:0] n,
    input  logic [M-1:0] lim,
    output logic [M-1:0] i,
    output logic         z,
    output logic         tc,
    output logic         ovf,
    output logic         err
);

    logic [M-1:0] r_i;
    logic         r_tc;
    logic         r_ovf;
    logic         r_err;

    logic [M-1:0] w_next;
    logic         w_bnd;
    logic         w_lerr;

    contador_next #(
        .M       (M),
        .RST_VAL (RST_VAL)
    ) u_next (
        .i_opc  (opc),
        .i_mode (mode),
        .i_cnt  (r_i),
        .i_n    (n),
        .i_lim  (lim),
        .o_next (w_next),
        .o_bnd  (w_bnd),
        .o_lerr (w_lerr)
    );

    // State registers: reset and CLR restore defaults, otherwise follow next-state logic
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i   <= RST_VAL;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
        end else if (opc == OPC_CLR) begin
            r_i   <= RST_VAL;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_i  <= w_next;
            r_tc <= w_bnd;
            if (w_bnd)  r_ovf <= 1'b1;
            if (w_lerr) r_err <= 1'b1;
        end
    end

    assign i   = r_i;
    assign tc  = r_tc;
    assign ovf = r_ovf;
    assign err = r_err;
    assign z   = (r_i == '0);

endmodule
